dmi_arbiter: RTL and testbench

DMI_ARBITER -- requirements
Module: dmi_arbiter

---
 rtl/dmi_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmi_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_arbiter.sv
// rtl/dmi_arbiter.sv - two-requester DMI arbiter, one outstanding transaction
// Optional feature macro: DMI_ARBITER_TIMEOUT_EN (response timeout with drain of late responses)
module dmi_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  io_in_req_valid,
  output logic [1:0]  io_in_req_ready,
  input  logic [13:0] io_in_req_bits_addr,
  input  logic [63:0] io_in_req_bits_data,
  input  logic [3:0]  io_in_req_bits_op,
  output logic [1:0]  io_in_resp_valid,
  input  logic [1:0]  io_in_resp_ready,
  output logic [31:0] io_in_resp_bits_data,
  output logic [1:0]  io_in_resp_bits_resp,
  output logic        io_out_req_valid,
  input  logic        io_out_req_ready,
  output logic [6:0]  io_out_req_bits_addr,
  output logic [31:0] io_out_req_bits_data,
  output logic [1:0]  io_out_req_bits_op,
  input  logic        io_out_resp_valid,
  output logic        io_out_resp_ready,
  input  logic [31:0] io_out_resp_bits_data,
  input  logic [1:0]  io_out_resp_bits_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
`ifdef DMI_ARBITER_TIMEOUT_EN
    , TOUT = 2'd3
`endif
  } state_e;

  localparam logic [1:0] RESP_TIMEOUT = 2'd2;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  op_q, op_d;

`ifdef DMI_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[15:0];
  logic [15:0] cnt_q, cnt_d;
  logic        drain_q, drain_d;
`endif

  logic grant_any;
  logic grant_idx;
  logic owner_ready;

  // Pick the requester to serve: the only valid one, or on a tie the one that was not served last
  always_comb begin
    grant_any = |io_in_req_valid;
    if (io_in_req_valid == 2'b11) begin
      grant_idx = ~last_q;
    end else begin
      grant_idx = io_in_req_valid[1];
    end
  end

  assign owner_ready          = io_in_resp_ready[owner_q];
  assign io_out_req_bits_addr = addr_q;
  assign io_out_req_bits_data = data_q;
  assign io_out_req_bits_op   = op_q;

  // Next-state and output decode for the transaction FSM
  always_comb begin
    state_d              = state_q;
    last_d               = last_q;
    owner_d              = owner_q;
    addr_d               = addr_q;
    data_d               = data_q;
    op_d                 = op_q;
    io_in_req_ready      = 2'b00;
    io_in_resp_valid     = 2'b00;
    io_in_resp_bits_data = 32'd0;
    io_in_resp_bits_resp = 2'd0;
    io_out_req_valid     = 1'b0;
    io_out_resp_ready    = 1'b0;
`ifdef DMI_ARBITER_TIMEOUT_EN
    cnt_d                = cnt_q;
    drain_d              = drain_q;
    // A response orphaned by a timeout is swallowed wherever it turns up
    io_out_resp_ready    = drain_q;
    if (drain_q && io_out_resp_valid) begin
      drain_d = 1'b0;
    end
`endif
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          io_in_req_ready[grant_idx] = 1'b1;
          owner_d = grant_idx;
          addr_d  = grant_idx ? io_in_req_bits_addr[13:7]  : io_in_req_bits_addr[6:0];
          data_d  = grant_idx ? io_in_req_bits_data[63:32] : io_in_req_bits_data[31:0];
          op_d    = grant_idx ? io_in_req_bits_op[3:2]     : io_in_req_bits_op[1:0];
          state_d = REQ;
        end
      end
      REQ: begin
        io_out_req_valid = 1'b1;
        if (io_out_req_ready) begin
          state_d = RESP;
`ifdef DMI_ARBITER_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      RESP: begin
`ifdef DMI_ARBITER_TIMEOUT_EN
        if (!drain_q) begin
`endif
          io_in_resp_valid[owner_q] = io_out_resp_valid;
          io_out_resp_ready         = owner_ready;
          if (io_out_resp_valid) begin
            io_in_resp_bits_data = io_out_resp_bits_data;
            io_in_resp_bits_resp = io_out_resp_bits_resp;
          end
          if (io_out_resp_valid && owner_ready) begin
            last_d  = owner_q;
            state_d = IDLE;
          end
`ifdef DMI_ARBITER_TIMEOUT_EN
        end
        if (!io_out_resp_valid) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TIMEOUT_LIMIT) begin
            state_d = TOUT;
            drain_d = 1'b1;
          end
        end
`endif
      end
`ifdef DMI_ARBITER_TIMEOUT_EN
      TOUT: begin
        io_in_resp_valid[owner_q] = 1'b1;
        io_in_resp_bits_resp      = RESP_TIMEOUT;
        if (owner_ready) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched payload registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= 7'd0;
      data_q  <= 32'd0;
      op_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
    end
  end

`ifdef DMI_ARBITER_TIMEOUT_EN
  // Timeout counter and drain flag
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= 16'd0;
      drain_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb/tb_dmi_arbiter.sv - self-checking bench for dmi_arbiter
module tb_dmi_arbiter;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  in_req_valid;
  logic [1:0]  in_req_ready;
  logic [13:0] in_req_addr;
  logic [63:0] in_req_data;
  logic [3:0]  in_req_op;
  logic [1:0]  in_resp_valid;
  logic [1:0]  in_resp_ready;
  logic [31:0] in_resp_data;
  logic [1:0]  in_resp_resp;
  logic        out_req_valid;
  logic        out_req_ready;
  logic [6:0]  out_req_addr;
  logic [31:0] out_req_data;
  logic [1:0]  out_req_op;
  logic        out_resp_valid;
  logic        out_resp_ready;
  logic [31:0] out_resp_data;
  logic [1:0]  out_resp_resp;

  int errors = 0;
  int checks = 0;

  dmi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_in_req_valid       (in_req_valid),
    .io_in_req_ready       (in_req_ready),
    .io_in_req_bits_addr   (in_req_addr),
    .io_in_req_bits_data   (in_req_data),
    .io_in_req_bits_op     (in_req_op),
    .io_in_resp_valid      (in_resp_valid),
    .io_in_resp_ready      (in_resp_ready),
    .io_in_resp_bits_data  (in_resp_data),
    .io_in_resp_bits_resp  (in_resp_resp),
    .io_out_req_valid      (out_req_valid),
    .io_out_req_ready      (out_req_ready),
    .io_out_req_bits_addr  (out_req_addr),
    .io_out_req_bits_data  (out_req_data),
    .io_out_req_bits_op    (out_req_op),
    .io_out_resp_valid     (out_resp_valid),
    .io_out_resp_ready     (out_resp_ready),
    .io_out_resp_bits_data (out_resp_data),
    .io_out_resp_bits_resp (out_resp_resp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who holds the bus, whether the request went downstream,
  // how long the response has been awaited, and whether a late response must be swallowed.
  bit          m_ok = 0;
  bit          m_active, m_issued, m_tout, m_swallow, m_last;
  int          m_owner, m_wait;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_op;

  always @(negedge clock) begin : compare
    logic [1:0]  e_req_ready, e_resp_valid, e_resp_resp;
    logic [31:0] e_resp_data;
    logic        e_out_resp_ready, e_out_req_valid, chk_orr, finish, set_sw, clr_sw;
    int          win;
    e_req_ready = 2'b00; e_resp_valid = 2'b00; e_resp_resp = 2'd0; e_resp_data = 32'd0;
    e_out_resp_ready = 1'b0; chk_orr = 1'b1; finish = 1'b0; set_sw = 1'b0; clr_sw = 1'b0;
    win = (in_req_valid == 2'b11) ? (m_last ? 0 : 1) : (in_req_valid[1] ? 1 : 0);
    e_out_req_valid = m_active && !m_issued;
    if (!m_active) begin
      if (in_req_valid != 2'b00) e_req_ready[win] = 1'b1;
      e_out_resp_ready = m_swallow;
    end else if (!m_issued) begin
      e_out_resp_ready = m_swallow;
    end else if (!m_tout) begin
      if (m_swallow) begin
        e_out_resp_ready = 1'b1;
      end else begin
        e_resp_valid[m_owner] = out_resp_valid;
        e_out_resp_ready = in_resp_ready[m_owner];
        if (out_resp_valid) begin
          e_resp_data = out_resp_data;
          e_resp_resp = out_resp_resp;
        end
      end
    end else begin
      e_resp_valid[m_owner] = 1'b1;
      e_resp_resp = 2'd2;
      chk_orr = 1'b0;
    end
    if (m_ok) begin
      chk("in_req_ready", in_req_ready, e_req_ready);
      chk("out_req_valid", out_req_valid, e_out_req_valid);
      chk("in_resp_valid", in_resp_valid, e_resp_valid);
      chk("in_resp_data", in_resp_data, e_resp_data);
      chk("in_resp_resp", in_resp_resp, e_resp_resp);
      if (chk_orr) chk("out_resp_ready", out_resp_ready, e_out_resp_ready);
      if (e_out_req_valid) begin
        chk("out_req_addr", out_req_addr, m_addr);
        chk("out_req_data", out_req_data, m_data);
        chk("out_req_op", out_req_op, m_op);
      end
    end
    if (reset) begin
      m_ok = 1; m_active = 0; m_issued = 0; m_tout = 0; m_swallow = 0; m_last = 1;
      m_owner = 0; m_wait = 0;
    end else if (m_ok) begin
      if (m_swallow && out_resp_valid) clr_sw = 1'b1;
      if (!m_active) begin
        if (in_req_valid != 2'b00) begin
          m_active = 1; m_issued = 0; m_owner = win;
          m_addr = in_req_addr[7*win +: 7];
          m_data = in_req_data[32*win +: 32];
          m_op   = in_req_op[2*win +: 2];
        end
      end else if (!m_issued) begin
        if (out_req_ready) begin
          m_issued = 1; m_wait = 0;
        end
      end else if (!m_tout) begin
        if (!m_swallow && out_resp_valid && in_resp_ready[m_owner]) begin
          finish = 1'b1;
        end else if (!out_resp_valid) begin
          m_wait++;
`ifdef DMI_ARBITER_TIMEOUT_EN
          if (m_wait == TO) begin
            m_tout = 1; set_sw = 1'b1;
          end
`endif
        end
      end else if (in_resp_ready[m_owner]) begin
        finish = 1'b1;
      end
      if (finish) begin
        m_last = (m_owner == 1); m_active = 0; m_issued = 0; m_tout = 0;
      end
      if (set_sw) m_swallow = 1;
      else if (clr_sw) m_swallow = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    in_req_addr[7*i +: 7]  = a;
    in_req_data[32*i +: 32] = d;
    in_req_op[2*i +: 2]    = op;
  endtask

  task automatic resp(input logic v, input logic [31:0] d, input logic [1:0] r, input logic [1:0] rdy);
    out_resp_valid = v; out_resp_data = d; out_resp_resp = r; in_resp_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; in_req_valid = 0; in_req_addr = 0; in_req_data = 0; in_req_op = 0;
    in_resp_ready = 0; out_req_ready = 1; out_resp_valid = 0; out_resp_data = 0; out_resp_resp = 0;
    tick(); tick();
    reset = 0;
    @(negedge clock);
    chk("rst_in_req_ready", in_req_ready, 2'b00);
    chk("rst_out_req_valid", out_req_valid, 1'b0);
    chk("rst_in_resp_valid", in_resp_valid, 2'b00);
    chk("rst_out_resp_ready", out_resp_ready, 1'b0);
    chk("rst_out_req_addr", out_req_addr, 7'h00);
    tick();

    // single read
    set_req(0, 7'h11, 32'h0, 2'd1); in_req_valid = 2'b01;
    @(negedge clock); chk("t1_grant", in_req_ready, 2'b01); tick();
    in_req_valid = 2'b00;
    @(negedge clock);
    chk("t1_out_valid", out_req_valid, 1'b1);
    chk("t1_out_addr", out_req_addr, 7'h11);
    chk("t1_out_op", out_req_op, 2'd1);
    tick();
    resp(1, 32'hDEADBEEF, 2'd0, 2'b01);
    @(negedge clock);
    chk("t1_resp_valid", in_resp_valid, 2'b01);
    chk("t1_resp_data", in_resp_data, 32'hDEADBEEF);
    tick();
    resp(0, 0, 0, 2'b00);
    @(negedge clock); chk("t1_idle_resp_valid", in_resp_valid, 2'b00); tick();

    // tie after reset
    reset = 1; tick(); reset = 0;
    set_req(0, 7'h01, 32'h0, 2'd1); set_req(1, 7'h02, 32'hCAFEF00D, 2'd2); in_req_valid = 2'b11;
    @(negedge clock); chk("t2_tie_grant", in_req_ready, 2'b01); tick();
    in_req_valid = 2'b10;
    @(negedge clock);
    chk("t2_busy_ready", in_req_ready, 2'b00);
    chk("t2_out_addr0", out_req_addr, 7'h01);
    tick();
    resp(1, 32'h1111, 2'd0, 2'b11);
    @(negedge clock); chk("t2_resp0", in_resp_valid, 2'b01); tick();
    resp(0, 0, 0, 2'b00);
    @(negedge clock); chk("t2_grant1", in_req_ready, 2'b10); tick();
    in_req_valid = 2'b00;
    @(negedge clock);
    chk("t2_out_addr1", out_req_addr, 7'h02);
    chk("t2_out_data1", out_req_data, 32'hCAFEF00D);
    chk("t2_out_op1", out_req_op, 2'd2);
    tick();
    resp(1, 32'h2222, 2'd1, 2'b10);
    @(negedge clock);
    chk("t2_resp1", in_resp_valid, 2'b10);
    chk("t2_resp1_code", in_resp_resp, 2'd1);
    chk("t2_resp1_data", in_resp_data, 32'h2222);
    tick();
    resp(0, 0, 0, 2'b00);

    // backpressure downstream, requester 1 waiting meanwhile
    out_req_ready = 0;
    set_req(0, 7'h33, 32'h12345678, 2'd2); in_req_valid = 2'b01;
    @(negedge clock); chk("t3_grant", in_req_ready, 2'b01); tick();
    set_req(1, 7'h44, 32'h0, 2'd1); in_req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("t3_hold_valid", out_req_valid, 1'b1);
      chk("t3_hold_op", out_req_op, 2'd2);
      chk("t3_hold_data", out_req_data, 32'h12345678);
      chk("t3_hold_ready", in_req_ready, 2'b00);
      tick();
    end
    out_req_ready = 1;
    @(negedge clock); chk("t3_release", out_req_valid, 1'b1); tick();
    resp(1, 32'h5, 2'd0, 2'b01);
    @(negedge clock); chk("t3_resp", in_resp_valid, 2'b01); tick();
    resp(0, 0, 0, 2'b00);
    @(negedge clock); chk("t3_waiter_grant", in_req_ready, 2'b10); tick();
    in_req_valid = 2'b00;

    // reset in the middle of a response wait, with requester 0 queued
    tick();
    set_req(0, 7'h55, 32'h0, 2'd1); in_req_valid = 2'b01;
    @(negedge clock);
    chk("t4_wait_resp_valid", in_resp_valid, 2'b00);
    chk("t4_wait_ready", in_req_ready, 2'b00);
    tick();
    reset = 1; tick(); reset = 0;
    @(negedge clock);
    chk("t4_after_resp_valid", in_resp_valid, 2'b00);
    chk("t4_after_out_valid", out_req_valid, 1'b0);
    chk("t4_queued_grant", in_req_ready, 2'b01);
    tick();
    in_req_valid = 2'b00;
    @(negedge clock); chk("t4_out_addr", out_req_addr, 7'h55); tick();
    resp(1, 32'hABCD0123, 2'd0, 2'b01);
    @(negedge clock); chk("t4_resp_data", in_resp_data, 32'hABCD0123); tick();
    resp(0, 0, 0, 2'b00);

    // no downstream response
    set_req(1, 7'h66, 32'h0, 2'd1); in_req_valid = 2'b10;
    @(negedge clock); chk("t5_grant", in_req_ready, 2'b10); tick();
    in_req_valid = 2'b00;
    @(negedge clock); chk("t5_out_valid", out_req_valid, 1'b1); tick();
`ifdef DMI_ARBITER_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      @(negedge clock); chk("t5_pre_timeout", in_resp_valid, 2'b00); tick();
    end
    in_resp_ready = 2'b10;
    @(negedge clock);
    chk("t5_tout_valid", in_resp_valid, 2'b10);
    chk("t5_tout_resp", in_resp_resp, 2'd2);
    chk("t5_tout_data", in_resp_data, 32'h0);
    tick();
    resp(1, 32'hBAD, 2'd0, 2'b00);
    @(negedge clock);
    chk("t5_drain_ready", out_resp_ready, 1'b1);
    chk("t5_drain_no_fwd", in_resp_valid, 2'b00);
    tick();
    resp(0, 0, 0, 2'b00);
    @(negedge clock); chk("t5_drain_cleared", out_resp_ready, 1'b0); tick();
    set_req(0, 7'h77, 32'h0, 2'd1); in_req_valid = 2'b01;
    @(negedge clock); chk("t5_next_grant", in_req_ready, 2'b01); tick();
    in_req_valid = 2'b00;
    tick();
    resp(1, 32'h600D, 2'd0, 2'b01);
    @(negedge clock);
    chk("t5_next_valid", in_resp_valid, 2'b01);
    chk("t5_next_data", in_resp_data, 32'h600D);
    tick();
`else
    for (int k = 0; k < 10; k++) begin
      @(negedge clock); chk("t5_waits", in_resp_valid, 2'b00); tick();
    end
    resp(1, 32'h600D, 2'd0, 2'b10);
    @(negedge clock);
    chk("t5_late_valid", in_resp_valid, 2'b10);
    chk("t5_late_data", in_resp_data, 32'h600D);
    chk("t5_late_resp", in_resp_resp, 2'd0);
    tick();
`endif
    resp(0, 0, 0, 2'b00);
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
